// File: rtl/snn_pkg.sv
// Shared definitions for the SNN host controller: region codes, CSR map,
// STATUS bit positions and the host FSM encoding.
package snn_pkg;

    localparam logic [1:0] REG_CSR = 2'd0;
    localparam logic [1:0] REG_IMG = 2'd1;
    localparam logic [1:0] REG_W0  = 2'd2;
    localparam logic [1:0] REG_W1  = 2'd3;

    localparam logic [7:0] CSR_CTRL       = 8'h00;
    localparam logic [7:0] CSR_STATUS     = 8'h04;
    localparam logic [7:0] CSR_BETA       = 8'h08;
    localparam logic [7:0] CSR_VTH        = 8'h0C;
    localparam logic [7:0] CSR_TIMESTEPS  = 8'h10;
    localparam logic [7:0] CSR_SEED       = 8'h14;
    localparam logic [7:0] CSR_SPIKE_BASE = 8'h40;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_WERR = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSR_ACK,
        ST_WR_ACK,
        ST_RD_WAIT,
        ST_RD_ACK
    } host_state_e;

    function automatic logic [7:0] spike_offset(input int n);
        return CSR_SPIKE_BASE + 8'(4 * n);
    endfunction

endpackage

// File: rtl/snn_csr_bank.sv
// CSR registers of the SNN host controller: engine configuration, command
// pulses, sticky DONE/WERR flags and the spike-count readback mux.
module snn_csr_bank
    import snn_pkg::*;
#(
    parameter int OUTPUTS           = 10,
    parameter int DEFAULT_TIMESTEPS = 100
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 wr_en,
    input  logic [7:0]           offs,
    input  logic [9:0]           wdata,
    input  logic                 busy_i,
    input  logic                 done_i,
    input  logic                 werr_set,
    input  logic [8*OUTPUTS-1:0] spike_cnt_i,
    output logic [31:0]          rdata,
    output logic                 start_o,
    output logic                 abort_o,
    output logic                 set_seed_o,
    output logic [7:0]           beta_o,
    output logic [7:0]           vth_o,
    output logic [7:0]           seed_o,
    output logic [9:0]           timesteps_o
);

    logic [7:0] beta_q, beta_d, vth_q, vth_d, seed_q, seed_d;
    logic [9:0] ts_q, ts_d;
    logic       start_q, start_d, abort_q, abort_d, set_seed_q, set_seed_d;
    logic       done_q, done_d, werr_q, werr_d;
    logic [7:0] spk [OUTPUTS];

    for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_spk
        assign spk[gi] = spike_cnt_i[gi*8 +: 8];
    end

    always_comb begin
        beta_d     = beta_q;
        vth_d      = vth_q;
        seed_d     = seed_q;
        ts_d       = ts_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        set_seed_d = 1'b0;
        done_d     = done_q;
        werr_d     = werr_q;
        if (wr_en) begin
            case (offs)
                CSR_CTRL: begin
                    start_d = wdata[0] & ~busy_i;
                    abort_d = wdata[1];
                end
                CSR_STATUS: begin
                    if (wdata[STAT_DONE]) done_d = 1'b0;
                    if (wdata[STAT_WERR]) werr_d = 1'b0;
                end
                CSR_BETA:      beta_d = wdata[7:0];
                CSR_VTH:       vth_d  = wdata[7:0];
                CSR_TIMESTEPS: ts_d   = wdata;
                CSR_SEED: begin
                    seed_d     = wdata[7:0];
                    set_seed_d = 1'b1;
                end
                default: ;
            endcase
        end
        // Set has priority over a coincident write-1-to-clear.
        if (done_i)   done_d = 1'b1;
        if (werr_set) werr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            beta_q     <= '0;
            vth_q      <= '0;
            seed_q     <= '0;
            ts_q       <= 10'(DEFAULT_TIMESTEPS);
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            set_seed_q <= 1'b0;
            done_q     <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            beta_q     <= beta_d;
            vth_q      <= vth_d;
            seed_q     <= seed_d;
            ts_q       <= ts_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            set_seed_q <= set_seed_d;
            done_q     <= done_d;
            werr_q     <= werr_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (offs)
            CSR_STATUS: begin
                rdata[STAT_BUSY] = busy_i;
                rdata[STAT_DONE] = done_q;
                rdata[STAT_WERR] = werr_q;
            end
            CSR_BETA:      rdata[7:0] = beta_q;
            CSR_VTH:       rdata[7:0] = vth_q;
            CSR_TIMESTEPS: rdata[9:0] = ts_q;
            CSR_SEED:      rdata[7:0] = seed_q;
            default: begin
                for (int i = 0; i < OUTPUTS; i++) begin
                    if (offs == spike_offset(i)) rdata[7:0] = spk[i];
                end
            end
        endcase
    end

    assign start_o     = start_q;
    assign abort_o     = abort_q;
    assign set_seed_o  = set_seed_q;
    assign beta_o      = beta_q;
    assign vth_o       = vth_q;
    assign seed_o      = seed_q;
    assign timesteps_o = ts_q;

endmodule

// File: rtl/snn_host_ctrl.sv
// Wishbone host controller for the SNN core: address decode, SRAM port-0
// sequencing and CSR access. Define SNN_HOST_WRLOCK_EN to block SRAM writes while busy.
module snn_host_ctrl
    import snn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR         = 32'h3000_0000,
    parameter int          OUTPUTS           = 10,
    parameter int          DEFAULT_TIMESTEPS = 100
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic                 img_csb0_o,
    output logic                 w0_csb0_o,
    output logic                 w1_csb0_o,
    output logic                 mem_web0_o,
    output logic [9:0]           mem_addr0_o,
    output logic [7:0]           mem_din0_o,
    input  logic [7:0]           img_dout0_i,
    input  logic [7:0]           w0_dout0_i,
    input  logic [7:0]           w1_dout0_i,
    output logic                 start_o,
    output logic                 abort_o,
    output logic                 set_seed_o,
    output logic [7:0]           beta_o,
    output logic [7:0]           vth_o,
    output logic [7:0]           seed_o,
    output logic [9:0]           timesteps_o,
    input  logic                 busy_i,
    input  logic                 done_i,
    input  logic [8*OUTPUTS-1:0] spike_cnt_i
);

    host_state_e state_q, state_d;
    logic [1:0]  region_q, region_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] csr_rdata;
    logic [1:0]  region;
    logic [7:0]  sel_dout;
    logic        hit, idle_hit, wr_lock, csr_wr, werr_set, sram_go;
    logic        unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:10]};

    assign region   = wbs_adr_i[13:12];
    assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:14] == BASE_ADDR[31:14]);
    assign idle_hit = (state_q == ST_IDLE) & hit;

`ifdef SNN_HOST_WRLOCK_EN
    assign wr_lock = busy_i;
`else
    assign wr_lock = 1'b0;
`endif

    assign csr_wr   = idle_hit & (region == REG_CSR) & wbs_we_i;
    assign werr_set = idle_hit & (region != REG_CSR) & wbs_we_i & wr_lock;
    // The SRAM strobe is combinational in the IDLE cycle so read data is ready in RD_WAIT.
    assign sram_go  = idle_hit & ~wb_rst_i & (region != REG_CSR)
                    & ~(wbs_we_i & (wr_lock | ~wbs_sel_i[0]));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            region_q <= REG_CSR;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        case (region_q)
            REG_IMG: sel_dout = img_dout0_i;
            REG_W0:  sel_dout = w0_dout0_i;
            REG_W1:  sel_dout = w1_dout0_i;
            default: sel_dout = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        dat_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    region_d = region;
                    if (region == REG_CSR) begin
                        state_d = ST_CSR_ACK;
                        dat_d   = wbs_we_i ? 32'd0 : csr_rdata;
                    end else if (wbs_we_i) begin
                        state_d = ST_WR_ACK;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_ACK;
                dat_d   = {24'd0, sel_dout};
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o   = (state_q == ST_CSR_ACK) | (state_q == ST_WR_ACK) | (state_q == ST_RD_ACK);
        wbs_dat_o   = dat_q;
        img_csb0_o  = 1'b1;
        w0_csb0_o   = 1'b1;
        w1_csb0_o   = 1'b1;
        mem_web0_o  = 1'b1;
        mem_addr0_o = '0;
        mem_din0_o  = '0;
        if (sram_go) begin
            img_csb0_o  = (region != REG_IMG);
            w0_csb0_o   = (region != REG_W0);
            w1_csb0_o   = (region != REG_W1);
            mem_web0_o  = ~wbs_we_i;
            mem_addr0_o = wbs_adr_i[11:2];
            mem_din0_o  = wbs_we_i ? wbs_dat_i[7:0] : 8'd0;
        end
    end

    snn_csr_bank #(
        .OUTPUTS          (OUTPUTS),
        .DEFAULT_TIMESTEPS(DEFAULT_TIMESTEPS)
    ) u_csr (
        .clk        (wb_clk_i),
        .srst       (wb_rst_i),
        .wr_en      (csr_wr),
        .offs       (wbs_adr_i[7:0]),
        .wdata      (wbs_dat_i[9:0]),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .werr_set   (werr_set),
        .spike_cnt_i(spike_cnt_i),
        .rdata      (csr_rdata),
        .start_o    (start_o),
        .abort_o    (abort_o),
        .set_seed_o (set_seed_o),
        .beta_o     (beta_o),
        .vth_o      (vth_o),
        .seed_o     (seed_o),
        .timesteps_o(timesteps_o)
    );

endmodule

// File: doc/snn_host_ctrl.md
# snn_host_ctrl

Wishbone-facing host controller for the SNN inference core. Decodes host accesses into a CSR bank and the port-0 (rw) side of the image, weights-0 and weights-1 SRAMs, sequences SRAM read latency into Wishbone acks, and drives the start, abort and configuration signals of the inference engine. It sits between the Caravel Wishbone bus and `snn`'s datapath. The engine keeps exclusive use of the SRAM read-only port 1.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone window base; window size 16 KiB.
- OUTPUTS, 10: output neurons exposed for spike-count readback.
- DEFAULT_TIMESTEPS, 100: reset value of TIMESTEPS.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobes
- wbs_sel_i  in  4  byte selects; only sel[0] is honoured for SRAM writes
- wbs_adr_i, wbs_dat_i  in  32  address / write data
- wbs_ack_o  out  1  one-cycle ack
- wbs_dat_o  out  32  read data, zero-extended
- img_csb0_o, w0_csb0_o, w1_csb0_o  out  1  active-low chip selects, port 0
- mem_web0_o  out  1  active-low write enable, shared
- mem_addr0_o  out  10  shared port-0 address
- mem_din0_o  out  8  shared write data
- img_dout0_i, w0_dout0_i, w1_dout0_i  in  8  port-0 read data
- start_o, abort_o, set_seed_o  out  1  one-cycle pulses to the engine
- beta_o, vth_o, seed_o  out  8  engine configuration
- timesteps_o  out  10  engine configuration
- busy_i, done_i  in  1  engine is running / one-cycle completion pulse
- spike_cnt_i  in  8*OUTPUTS  flat output spike counters, neuron 0 in bits [7:0]

## Operation
- Hit condition: cyc&stb and adr[31:14]==BASE_ADDR[31:14]. A miss is never acked.
- Region select is adr[13:12]: 0 = CSR, 1 = image, 2 = weights-0, 3 = weights-1.
- SRAM word index is adr[11:2]. Each 32-bit word carries one byte in bits [7:0].
- CSR offsets (adr[7:0]):
  - 0x00 CTRL (write-only): bit0 start pulse, bit1 abort pulse.
  - 0x04 STATUS: bit0 busy_i (read-only), bit1 DONE (sticky, set by done_i, write 1 to clear), bit2 WERR (sticky, write 1 to clear).
  - 0x08 BETA.
  - 0x0C VTH.
  - 0x10 TIMESTEPS[9:0].
  - 0x14 SEED; a write also pulses set_seed_o.
  - 0x40 + 4*n: spike_cnt_i neuron n, read-only, for n < OUTPUTS.
  - Unmapped offsets read 0, ignore writes, and are still acked.
- A start write while busy_i=1 is ignored.
- A done_i pulse arriving in the same cycle as a DONE W1C write leaves DONE=1 (set wins).
- FSM states:
  - IDLE: on a hit go to CSR_ACK (CSR region), WR_ACK (SRAM write, with csb/web asserted this cycle), or RD_WAIT (SRAM read, with csb asserted and web high this cycle).
  - CSR_ACK, WR_ACK: ack, then IDLE.
  - RD_WAIT: capture the selected dout into a register at the cycle end, go to RD_ACK.
  - RD_ACK: ack with the captured data, then IDLE.
- Only one transaction is in flight. New hits are sampled only in IDLE.
- Reset mid-transaction returns to IDLE with no ack and all csb high.

## Timing
- Request visible at edge N. CSR read/write and SRAM write ack in cycle N+1. SRAM read ack in cycle N+2.
- ack lasts exactly one cycle. The master drops stb after ack. The FSM is in IDLE the cycle after ack.
- csb/web are asserted for exactly one cycle per access. All three csb stay high when idle.
- Reset values:
  - Outputs: ack 0, dat 0, all csb 1, web 1, addr 0, din 0, start/abort/set_seed 0, beta 0, vth 0, seed 0, timesteps DEFAULT_TIMESTEPS.
  - Registers: DONE 0, WERR 0.
- CSR writes update outputs at the edge that enters CSR_ACK. Pulses go high for that one cycle.

## Configuration
- SNN_HOST_WRLOCK_EN defined: an SRAM write while busy_i=1 is acked on the normal schedule. No csb/web is asserted and WERR is set. Reads while busy are still permitted.
- Not defined: SRAM writes proceed regardless of busy_i, and WERR never sets (reads 0).

## Structure
- Shared package snn_pkg holds:
  - Region codes.
  - CSR offset constants.
  - FSM state encoding.
  - STATUS bit indices.
- One sub-module is natural: snn_csr_bank, which holds the CSR registers, pulses and sticky bits. The FSM, decode and SRAM sequencing stay in the top module.

## Test plan
- Write 0x3000_1004 data 0xA5, then read it back: image csb0 low with web low for one cycle at addr 1, din 0xA5; read acks 2 cycles after request with dat 0x0000_00A5.
- Write VTH=0x40 and TIMESTEPS=0x3FF, then write CTRL=1: vth_o=0x40, timesteps_o=0x3FF, one start_o pulse; reading 0x10 returns 0x3FF.
- Hold busy_i=1, write 0x3000_2000 (weights-0) with SNN_HOST_WRLOCK_EN defined: ack, w0_csb0 stays high, STATUS=0x5. Without the macro: write occurs and STATUS=0x1.
- Pulse done_i in the same cycle as a STATUS write of 0x2: DONE remains 1. A later write of 0x2 clears it.
- Drive spike_cnt_i neuron 9 = 0x37 and read 0x3000_0064: returns 0x37. Access 0x3000_4000: no ack for 10 cycles.
- Assert wb_rst_i during RD_WAIT: no ack, all csb high, FSM in IDLE, and all CSR outputs at reset values.
